// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the RV32M mul/div sequencer
package muldiv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPECIAL,
        S_MUL_WAIT,
        S_DIV_WAIT,
        S_RESP,
        S_DRAIN
    } state_e;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;

endpackage

// File: rtl/muldiv_special_detect.sv
// rtl/muldiv_special_detect.sv - divide special-case detection, sign flags and operand magnitudes
module muldiv_special_detect
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic            is_special,
    output logic [XLEN-1:0] special_val,
    output logic            neg_res,
    output logic [XLEN-1:0] div_op1,
    output logic [XLEN-1:0] div_op2
);

    localparam logic [XLEN-1:0] ALL_ONES = '1;
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    logic is_signed;
    logic is_rem;
    logic s1;
    logic s2;
    logic div_zero;
    logic overflow;

    assign is_signed = funct3[2] & ~funct3[0];
    assign is_rem    = funct3[1];
    assign s1        = is_signed & rs1_val[XLEN-1];
    assign s2        = is_signed & rs2_val[XLEN-1];
    assign div_zero  = (rs2_val == '0);
    assign overflow  = is_signed && (rs1_val == MIN_NEG) && (rs2_val == ALL_ONES);

    assign is_special  = funct3[2] & (div_zero | overflow);
    assign special_val = div_zero ? (is_rem ? rs1_val : ALL_ONES)
                                  : (is_rem ? '0 : MIN_NEG);

    // Remainder takes the dividend's sign; quotient is negative when signs differ.
    assign neg_res = is_rem ? s1 : (s1 ^ s2);
    assign div_op1 = s1 ? -rs1_val : rs1_val;
    assign div_op2 = s2 ? -rs2_val : rs2_val;

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - EX-stage sequencer for the iterative RV32M multiplier and divider
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 40
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            op_valid,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            stall,
    output logic            res_valid,
    output logic [XLEN-1:0] res_data,
    output logic [4:0]      res_rd,
    output logic            err,
    output logic            startM,
    output logic [1:0]      mul_opcode,
    input  logic            doneM,
    input  logic [XLEN-1:0] result_mul,
    output logic            startD,
    output logic [1:0]      div_opcode,
    input  logic            doneD,
    input  logic [XLEN-1:0] result_divide,
    output logic [XLEN-1:0] mdu_op1,
    output logic [XLEN-1:0] mdu_op2
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_e          state;
    state_e          state_n;
    logic [CW-1:0]   cnt;
    logic            is_div_q;
    logic            neg_q;
    logic [4:0]      rd_q;
    logic            issue;
    logic            tmo;
    logic            in_wait;
    logic            first_cyc;
    logic            timed_out;
    logic            unit_done;
    logic            is_special;
    logic            neg_res;
    logic [XLEN-1:0] special_val;
    logic [XLEN-1:0] div_op1;
    logic [XLEN-1:0] div_op2;

    muldiv_special_detect #(.XLEN(XLEN)) u_detect (
        .funct3      (funct3),
        .rs1_val     (rs1_val),
        .rs2_val     (rs2_val),
        .is_special  (is_special),
        .special_val (special_val),
        .neg_res     (neg_res),
        .div_op1     (div_op1),
        .div_op2     (div_op2)
    );

    assign in_wait   = (state == S_MUL_WAIT) || (state == S_DIV_WAIT) || (state == S_DRAIN);
    assign first_cyc = (cnt == '0);
    assign timed_out = (cnt == CW'(TIMEOUT - 1));
    // done is level-type and still reflects the previous op on the first wait cycle
    assign unit_done = is_div_q ? doneD : doneM;

    always_comb begin
        state_n   = state;
        stall     = 1'b0;
        res_valid = 1'b0;
        issue     = 1'b0;
        tmo       = 1'b0;
        case (state)
            S_IDLE: begin
                if (op_valid && !flush) begin
                    issue = 1'b1;
                    if (!funct3[2])      state_n = S_MUL_WAIT;
                    else if (is_special) state_n = S_SPECIAL;
                    else                 state_n = S_DIV_WAIT;
                end
            end
            S_SPECIAL, S_RESP: begin
                res_valid = !flush;
                state_n   = S_IDLE;
            end
            S_MUL_WAIT, S_DIV_WAIT: begin
                stall = 1'b1;
                if (flush) begin
                    state_n = S_DRAIN;
                end else if (!first_cyc && unit_done) begin
                    state_n = S_RESP;
                end else if (timed_out) begin
                    state_n = S_IDLE;
                    tmo     = 1'b1;
                end
            end
            S_DRAIN: begin
                // Units cannot abort; hold off a new op until the old one finishes.
                stall = op_valid;
                if (!first_cyc && unit_done) begin
                    state_n = S_IDLE;
                end else if (timed_out) begin
                    state_n = S_IDLE;
                    tmo     = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rd_q       <= '0;
            res_data   <= '0;
            res_rd     <= '0;
            err        <= 1'b0;
            startM     <= 1'b0;
            startD     <= 1'b0;
            mul_opcode <= '0;
            div_opcode <= '0;
            mdu_op1    <= '0;
            mdu_op2    <= '0;
        end else begin
            state  <= state_n;
            err    <= tmo;
            startM <= 1'b0;
            startD <= 1'b0;

            if (state_n != state) begin
                cnt <= '0;
            end else if (in_wait) begin
                cnt <= cnt + 1'b1;
            end

            if (issue) begin
                is_div_q <= funct3[2];
                neg_q    <= neg_res;
                rd_q     <= rd_in;
                if (!funct3[2]) begin
                    startM     <= 1'b1;
                    mul_opcode <= funct3[1:0];
                    mdu_op1    <= rs1_val;
                    mdu_op2    <= rs2_val;
                end else if (is_special) begin
                    res_data <= special_val;
                    res_rd   <= rd_in;
                end else begin
                    startD     <= 1'b1;
                    div_opcode <= {funct3[1], 1'b1};
                    mdu_op1    <= div_op1;
                    mdu_op2    <= div_op2;
                end
            end

            if (state_n == S_RESP) begin
                res_rd <= rd_q;
                if (is_div_q) res_data <= neg_q ? -result_divide : result_divide;
                else          res_data <= result_mul;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - self-checking bench for muldiv_ctrl with modelled mul/div units
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1_val = '0;
    logic [31:0] rs2_val = '0;
    logic [4:0]  rd_in = '0;
    logic        flush = 1'b0;
    logic        stall, res_valid, err, startM, startD;
    logic [31:0] res_data, mdu_op1, mdu_op2;
    logic [4:0]  res_rd;
    logic [1:0]  mul_opcode, div_opcode;
    logic        doneM = 1'b0;
    logic        doneD = 1'b0;
    logic [31:0] result_mul = '0;
    logic [31:0] result_divide = '0;

    muldiv_ctrl #(.XLEN(32), .TIMEOUT(40)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .funct3(funct3),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in), .flush(flush),
        .stall(stall), .res_valid(res_valid), .res_data(res_data), .res_rd(res_rd),
        .err(err), .startM(startM), .mul_opcode(mul_opcode), .doneM(doneM),
        .result_mul(result_mul), .startD(startD), .div_opcode(div_opcode),
        .doneD(doneD), .result_divide(result_divide), .mdu_op1(mdu_op1), .mdu_op2(mdu_op2)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int n_spur = 0;

    function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, sbu;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        sbu = longint'({32'h0, b});
        p   = '0;
        case (f3)
            F3_MUL:    begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
            F3_MULH:   begin p = sa * sb;  return p[63:32]; end
            F3_MULHSU: begin p = sa * sbu; return p[63:32]; end
            F3_MULHU:  begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            F3_DIV: begin
                if (b == 32'h0) return DIV_ZERO_Q;
                if (a == INT_MIN && b == 32'hFFFF_FFFF) return INT_MIN;
                p = sa / sb;
                return p[31:0];
            end
            F3_DIVU: return (b == 32'h0) ? DIV_ZERO_Q : a / b;
            F3_REM: begin
                if (b == 32'h0) return a;
                if (a == INT_MIN && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb;
                return p[31:0];
            end
            default: return (b == 32'h0) ? a : a % b;
        endcase
    endfunction

    // Unit models: done rises N cycles after the start cycle and stays high until the next start.
    int          m_cnt = 0;
    int          d_cnt = 0;
    logic        hang_d = 1'b0;
    logic [31:0] m_op1 = '0, m_op2 = '0, d_op1 = '0, d_op2 = '0, m_pend = '0, d_pend = '0;
    logic [1:0]  m_opc = '0, d_opc = '0;

    always @(posedge clk) begin
        if (startM === 1'b1) begin
            m_cnt  <= 32;
            doneM  <= 1'b0;
            m_op1  <= mdu_op1;
            m_op2  <= mdu_op2;
            m_opc  <= mul_opcode;
            m_pend <= ref_mdu({1'b0, mul_opcode}, mdu_op1, mdu_op2);
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                doneM      <= 1'b1;
                result_mul <= m_pend;
            end
        end
        if (startD === 1'b1) begin
            d_cnt  <= 33;
            doneD  <= 1'b0;
            d_op1  <= mdu_op1;
            d_op2  <= mdu_op2;
            d_opc  <= div_opcode;
            d_pend <= (mdu_op2 == 32'h0) ? 32'hFFFF_FFFF
                    : (div_opcode[1] ? mdu_op1 % mdu_op2 : mdu_op1 / mdu_op2);
        end else if (d_cnt != 0) begin
            d_cnt <= d_cnt - 1;
            if (d_cnt == 1 && !hang_d) begin
                doneD         <= 1'b1;
                result_divide <= d_pend;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] got, output logic [4:0] grd,
                          output int lat, output int hold, output int stalls,
                          output int nm, output int nd, output logic ok);
        got = '0; grd = '0; lat = 0; hold = 0; stalls = 0; nm = 0; nd = 0; ok = 1'b0;
        @(posedge clk); #1;
        op_valid = 1'b1; funct3 = f3; rs1_val = a; rs2_val = b; rd_in = rd;
        @(negedge clk);
        while (stall && hold < 100) begin
            if (res_valid) n_spur++;
            hold++;
            @(posedge clk); #1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        op_valid = 1'b0;
        for (int g = 1; g < 200; g++) begin
            @(negedge clk);
            if (stall)  stalls++;
            if (startM) nm++;
            if (startD) nd++;
            if (res_valid) begin
                got = res_data; grd = res_rd; lat = g; ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          kind;   // 0 multiply, 1 divide through the unit, 2 short-circuited
        logic [31:0] u1;
        logic [31:0] u2;
    } vec_t;

    vec_t        tbl[13];
    logic [31:0] got, a, b;
    logic [4:0]  grd, rd;
    logic [2:0]  f3;
    int          lat, hold, stalls, nm, nd, err_cyc, n_err, n_rv;
    logic        ok;

    initial begin
        tbl[0]  = '{F3_DIV,    32'd20,         32'hFFFF_FFFD, 32'hFFFF_FFFA, 1, 32'd20,         32'd3};
        tbl[1]  = '{F3_REM,    32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE, 1, 32'd20,         32'd3};
        tbl[2]  = '{F3_REMU,   32'd20,         32'd3,         32'd2,         1, 32'd20,         32'd3};
        tbl[3]  = '{F3_DIVU,   32'd7,          32'd0,         32'hFFFF_FFFF, 2, 32'd0,          32'd0};
        tbl[4]  = '{F3_REM,    32'd7,          32'd0,         32'd7,         2, 32'd0,          32'd0};
        tbl[5]  = '{F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2, 32'd0,          32'd0};
        tbl[6]  = '{F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         2, 32'd0,          32'd0};
        tbl[7]  = '{F3_MULH,   32'h8000_0000,  32'd2,         32'hFFFF_FFFF, 0, 32'h8000_0000,  32'd2};
        tbl[8]  = '{F3_DIV,    32'h8000_0000,  32'd2,         32'hC000_0000, 1, 32'h8000_0000,  32'd2};
        tbl[9]  = '{F3_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1, 32'h8000_0000,  32'hFFFF_FFFF};
        tbl[10] = '{F3_MUL,    32'hFFFF_FFFD,  32'd5,         32'hFFFF_FFF1, 0, 32'hFFFF_FFFD,  32'd5};
        tbl[11] = '{F3_REMU,   32'd5,          32'd0,         32'd5,         2, 32'd0,          32'd0};
        tbl[12] = '{F3_DIV,    32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'd3,         1, 32'd7,          32'd2};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {stall, res_valid, res_data, res_rd, err, startM, mul_opcode,
                              startD, div_opcode}, 64'h0);
        chk("reset_operands", {mdu_op1, mdu_op2}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_op(tbl[i].f3, tbl[i].a, tbl[i].b, 5'(i + 1), got, grd, lat, hold, stalls, nm, nd, ok);
            chk($sformatf("v%0d_valid", i), ok, 1);
            chk($sformatf("v%0d_data", i), got, tbl[i].exp);
            chk($sformatf("v%0d_rd", i), grd, 64'(i + 1));
            if (tbl[i].kind == 2) begin
                chk($sformatf("v%0d_latency", i), lat, 1);
                chk($sformatf("v%0d_starts", i), nm + nd, 0);
                chk($sformatf("v%0d_stalls", i), stalls, 0);
            end else if (tbl[i].kind == 0) begin
                chk($sformatf("v%0d_latency", i), lat, 35);
                chk($sformatf("v%0d_starts", i), {nm[7:0], nd[7:0]}, 16'h0100);
                chk($sformatf("v%0d_stalls", i), stalls, 34);
                chk($sformatf("v%0d_unit_ops", i), {m_op1, m_op2}, {tbl[i].u1, tbl[i].u2});
                chk($sformatf("v%0d_opcode", i), m_opc, tbl[i].f3[1:0]);
            end else begin
                chk($sformatf("v%0d_latency", i), lat, 36);
                chk($sformatf("v%0d_starts", i), {nm[7:0], nd[7:0]}, 16'h0001);
                chk($sformatf("v%0d_stalls", i), stalls, 35);
                chk($sformatf("v%0d_unit_ops", i), {d_op1, d_op2}, {tbl[i].u1, tbl[i].u2});
                chk($sformatf("v%0d_opcode", i), d_opc, {tbl[i].f3[1], 1'b1});
            end
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("res_data_hold", {res_valid, res_data}, {1'b0, tbl[12].exp});

        // Flush a divide at its fifth wait cycle, then present a multiply during DRAIN.
        n_spur = 0;
        @(posedge clk); #1;
        op_valid = 1'b1; funct3 = F3_DIV; rs1_val = 32'd100; rs2_val = 32'd7; rd_in = 5'd9;
        @(posedge clk); #1;
        op_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        chk("flush_no_valid", res_valid, 0);
        chk("flush_wait_stall", stall, 1);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("drain_stall_idle", stall, 0);
        run_op(F3_MUL, 32'd6, 32'd7, 5'd11, got, grd, lat, hold, stalls, nm, nd, ok);
        chk("drain_holdoff_cycles", hold, 29);
        chk("drain_no_valid", n_spur, 0);
        chk("after_drain_data", {ok, got, grd}, {1'b1, 32'd42, 5'd11});
        chk("after_drain_starts", {nm[7:0], nd[7:0]}, 16'h0100);

        // Reset in the middle of a divide wait.
        @(posedge clk); #1;
        op_valid = 1'b1; funct3 = F3_DIV; rs1_val = 32'd99; rs2_val = 32'd4; rd_in = 5'd5;
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_outputs", {stall, res_valid, res_data, res_rd, err, startM, mul_opcode,
                                 startD, div_opcode}, 64'h0);
        chk("midreset_operands", {mdu_op1, mdu_op2}, 64'h0);
        run_op(F3_DIVU, 32'd100, 32'd7, 5'd6, got, grd, lat, hold, stalls, nm, nd, ok);
        chk("post_reset_op", {ok, got, grd}, {1'b1, 32'd14, 5'd6});
        chk("post_reset_latency", lat, 36);

        // Divider that never finishes: expect a single err pulse and no result.
        hang_d = 1'b1;
        err_cyc = -1; n_err = 0; n_rv = 0;
        @(posedge clk); #1;
        op_valid = 1'b1; funct3 = F3_DIV; rs1_val = 32'd50; rs2_val = 32'd5; rd_in = 5'd3;
        @(posedge clk); #1;
        op_valid = 1'b0;
        for (int c = 1; c < 60; c++) begin
            @(negedge clk);
            if (err) begin
                n_err++;
                if (err_cyc < 0) err_cyc = c;
            end
            if (res_valid) n_rv++;
            @(posedge clk); #1;
        end
        hang_d = 1'b0;
        @(negedge clk);
        chk("timeout_err_cycle", err_cyc, 41);
        chk("timeout_err_width", n_err, 1);
        chk("timeout_no_valid", n_rv, 0);
        chk("timeout_idle_stall", stall, 0);

        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? INT_MIN : 32'($urandom);
            case ($urandom_range(0, 4))
                0:       b = 32'h0;
                1:       b = 32'hFFFF_FFFF;
                default: b = 32'($urandom);
            endcase
            rd = 5'($urandom);
            run_op(f3, a, b, rd, got, grd, lat, hold, stalls, nm, nd, ok);
            chk($sformatf("rnd%0d_valid", i), ok, 1);
            chk($sformatf("rnd%0d_f3_%0d_%h_%h", i, f3, a, b), got, ref_mdu(f3, a, b));
            chk($sformatf("rnd%0d_rd", i), grd, rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
